window_watchdog_core: RTL

Windowed watchdog engine fed directly by configuration_register. It consumes FWLEN, SWLEN, RST_LMT, WDSRVC and INIT, and times a closed first window followed by an open second window. Early or missing services raise a reset pulse and are counted; reaching the reset limit locks the block in a safe state. Outputs drive the system reset line and the status/fault reporting logic.

---
 rtl/window_watchdog_core.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/window_watchdog_core.sv
// Windowed watchdog engine: closed first window, open second window, fault pulse and lockout.
// Optional build macro WDT_FLT_CLR_EN: an accepted service also clears the fault counter,
// so the reset limit counts consecutive faults instead of cumulative ones.
module window_watchdog_core #(
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned RST_PULSE = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] FWLEN,
  input  logic [7:0] SWLEN,
  input  logic [7:0] RST_LMT,
  input  logic       WDSRVC,
  input  logic       INIT,
  output logic       WDRST,
  output logic       SRVC_ACK,
  output logic       ENO,
  output logic [7:0] FLTCNT,
  output logic [1:0] LAST_FLT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFirst  = 3'd1,
    StSecond = 3'd2,
    StFault  = 3'd3,
    StLocked = 3'd4
  } state_e;

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned PuW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);
  localparam logic [PuW-1:0] PuMax = PuW'(RST_PULSE - 1);

  state_e         state_q, state_d;
  logic [PsW-1:0] presc_q, presc_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [PuW-1:0] pulse_q, pulse_d;
  logic [7:0]     fwlen_q, fwlen_d;
  logic [7:0]     swlen_q, swlen_d;
  logic [7:0]     lmt_q, lmt_d;
  logic           srvc_prev_q;
  logic           wdrst_q, wdrst_d;
  logic           ack_q, ack_d;
  logic           eno_q, eno_d;
  logic [7:0]     fltcnt_q, fltcnt_d;
  logic [1:0]     last_flt_q, last_flt_d;

  logic       srvc_evt;
  logic       tick;
  logic       expire;
  logic [7:0] cur_len;
  logic [7:0] fltcnt_inc;
  logic       enter_first, enter_second, enter_fault, advance;

  assign srvc_evt   = WDSRVC & ~srvc_prev_q;
  assign tick       = (presc_q == PsMax);
  assign cur_len    = (state_q == StSecond) ? swlen_q : fwlen_q;
  // A zero-length window expires on its first cycle regardless of the prescaler phase.
  assign expire     = (cur_len == 8'd0) ||
                      (tick && (({1'b0, cnt_q} + 9'd1) >= {1'b0, cur_len}));
  assign fltcnt_inc = (fltcnt_q == 8'hFF) ? fltcnt_q : fltcnt_q + 8'd1;

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    cnt_d        = cnt_q;
    pulse_d      = pulse_q;
    fwlen_d      = fwlen_q;
    swlen_d      = swlen_q;
    lmt_d        = lmt_q;
    wdrst_d      = wdrst_q;
    ack_d        = 1'b0;
    eno_d        = eno_q;
    fltcnt_d     = fltcnt_q;
    last_flt_d   = last_flt_q;
    enter_first  = 1'b0;
    enter_second = 1'b0;
    enter_fault  = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (INIT) enter_first = 1'b1;
      end
      StFirst: begin
        // Service wins over expiry here: a service on the last closed cycle is still early.
        if (srvc_evt) begin
          enter_fault = 1'b1;
          last_flt_d  = 2'b01;
        end else if (expire) begin
          enter_second = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      StSecond: begin
        if (srvc_evt) begin
          enter_first = 1'b1;
          ack_d       = 1'b1;
`ifdef WDT_FLT_CLR_EN
          fltcnt_d    = 8'd0;
`endif
        end else if (expire) begin
          enter_fault = 1'b1;
          last_flt_d  = 2'b10;
        end else begin
          advance = 1'b1;
        end
      end
      StFault: begin
        if (pulse_q == PuMax) begin
          if ((lmt_q != 8'd0) && (fltcnt_q >= lmt_q)) begin
            state_d    = StLocked;
            last_flt_d = 2'b11;
            eno_d      = 1'b1;
            wdrst_d    = 1'b1;
          end else begin
            enter_first = 1'b1;
          end
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      StLocked: state_d = StLocked;
      default:  state_d = StIdle;
    endcase

    if (advance) begin
      if (tick) begin
        presc_d = '0;
        cnt_d   = cnt_q + 8'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // Config is sampled only when a FIRST window starts; mid-window changes wait for the next one.
    if (enter_first) begin
      state_d = StFirst;
      fwlen_d = FWLEN;
      swlen_d = SWLEN;
      lmt_d   = RST_LMT;
      presc_d = '0;
      cnt_d   = 8'd0;
      wdrst_d = 1'b0;
    end

    if (enter_second) begin
      state_d = StSecond;
      presc_d = '0;
      cnt_d   = 8'd0;
    end

    if (enter_fault) begin
      state_d  = StFault;
      fltcnt_d = fltcnt_inc;
      wdrst_d  = 1'b1;
      pulse_d  = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      cnt_q       <= 8'd0;
      pulse_q     <= '0;
      fwlen_q     <= 8'd0;
      swlen_q     <= 8'd0;
      lmt_q       <= 8'd0;
      srvc_prev_q <= 1'b0;
      wdrst_q     <= 1'b0;
      ack_q       <= 1'b0;
      eno_q       <= 1'b0;
      fltcnt_q    <= 8'd0;
      last_flt_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
      fwlen_q     <= fwlen_d;
      swlen_q     <= swlen_d;
      lmt_q       <= lmt_d;
      srvc_prev_q <= WDSRVC;
      wdrst_q     <= wdrst_d;
      ack_q       <= ack_d;
      eno_q       <= eno_d;
      fltcnt_q    <= fltcnt_d;
      last_flt_q  <= last_flt_d;
    end
  end

  assign WDRST    = wdrst_q;
  assign SRVC_ACK = ack_q;
  assign ENO      = eno_q;
  assign FLTCNT   = fltcnt_q;
  assign LAST_FLT = last_flt_q;
  assign STATE    = state_q;

endmodule
